// File: rtl/vx_split_join_ext.sv
// Per-warp IPDOM reconvergence stack: divergent SPLIT pushes a frame, divergent JOIN
// yields the else path once and then restores the pre-split mask. Join result is registered.

module vx_sj_warp_stack #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 3,
  parameter int DW          = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   mark,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [NUM_THREADS-1:0] push_orig,
  input  logic [NUM_THREADS-1:0] push_else,
  input  logic [PC_WIDTH-1:0]    push_pc,
  output logic [DW-1:0]          sp,
  output logic [NUM_THREADS-1:0] top_orig,
  output logic [NUM_THREADS-1:0] top_else,
  output logic [PC_WIDTH-1:0]    top_pc,
  output logic                   top_taken
);
  logic [STACK_DEPTH-1:0][NUM_THREADS-1:0] f_orig, f_else;
  logic [STACK_DEPTH-1:0][PC_WIDTH-1:0]    f_pc;
  logic [STACK_DEPTH-1:0]                  f_taken;

  always_ff @(posedge clk) begin
    if (reset)      sp <= '0;
    else if (flush) sp <= '0;
    else if (push)  sp <= sp + DW'(1);
    else if (pop)   sp <= sp - DW'(1);
  end

  // Frame payload needs no reset: a frame is only read after a push wrote it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && sp == DW'(i)) begin
        f_orig[i]  <= push_orig;
        f_else[i]  <= push_else;
        f_pc[i]    <= push_pc;
        f_taken[i] <= 1'b0;
      end else if (mark && sp == DW'(i + 1)) begin
        f_taken[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    top_orig  = '0;
    top_else  = '0;
    top_pc    = '0;
    top_taken = 1'b0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == DW'(i + 1)) begin
        top_orig  = f_orig[i];
        top_else  = f_else[i];
        top_pc    = f_pc[i];
        top_taken = f_taken[i];
      end
    end
  end
endmodule

module vx_split_join_ext #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_WARPS   = 4,
  parameter  int NW_WIDTH    = 2,
  parameter  int PC_WIDTH    = 32,
  parameter  int STACK_DEPTH = 3,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [NW_WIDTH-1:0]     wid,
  input  logic                    split_valid,
  input  logic                    split_is_dvg,
  input  logic [NUM_THREADS-1:0]  split_then_tmask,
  input  logic [NUM_THREADS-1:0]  split_else_tmask,
  input  logic [PC_WIDTH-1:0]     split_next_pc,
  input  logic                    sjoin_valid,
  input  logic                    sjoin_is_dvg,
  input  logic                    flush_valid,
  input  logic [NW_WIDTH-1:0]     flush_wid,
  input  logic                    err_clear,
  output logic                    join_valid,
  output logic                    join_is_dvg,
  output logic                    join_is_else,
  output logic [NW_WIDTH-1:0]     join_wid,
  output logic [NUM_THREADS-1:0]  join_tmask,
  output logic [PC_WIDTH-1:0]     join_pc,
  output logic [NUM_WARPS*DW-1:0] depth,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic [NW_WIDTH-1:0]     err_wid
);
  localparam logic [DW-1:0] SP_FULL = DW'(STACK_DEPTH);

  logic [NUM_WARPS-1:0][DW-1:0]          sp;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0] top_orig, top_else;
  logic [NUM_WARPS-1:0][PC_WIDTH-1:0]    top_pc;
  logic [NUM_WARPS-1:0]                  top_taken, push_w, mark_w, pop_w, flush_w;

  logic [DW-1:0]          sel_sp;
  logic [NUM_THREADS-1:0] sel_orig, sel_else;
  logic [PC_WIDTH-1:0]    sel_pc;
  logic                   sel_taken;

  always_comb begin
    sel_sp    = '0;
    sel_orig  = '0;
    sel_else  = '0;
    sel_pc    = '0;
    sel_taken = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wid == NW_WIDTH'(w)) begin
        sel_sp    = sp[w];
        sel_orig  = top_orig[w];
        sel_else  = top_else[w];
        sel_pc    = top_pc[w];
        sel_taken = top_taken[w];
      end
    end
  end

  // An op colliding with a flush of its own warp is discarded outright.
  logic op_ok, do_split, do_join, dvg_join, push, overflow, underflow, mark, pop, new_err;
  assign op_ok     = valid && !(flush_valid && wid == flush_wid);
  assign do_split  = op_ok && split_valid;
  assign do_join   = op_ok && sjoin_valid && !split_valid;
  assign dvg_join  = do_join && sjoin_is_dvg;
  assign push      = do_split && split_is_dvg;
  assign overflow  = push && sel_sp == SP_FULL;
  assign underflow = dvg_join && sel_sp == '0;
  assign mark      = dvg_join && !underflow && !sel_taken;
  assign pop       = dvg_join && !underflow && sel_taken;
  assign new_err   = overflow || underflow;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic hit;
    assign hit        = wid == NW_WIDTH'(w);
    assign push_w[w]  = push && !overflow && hit;
    assign mark_w[w]  = mark && hit;
    assign pop_w[w]   = pop && hit;
    assign flush_w[w] = flush_valid && flush_wid == NW_WIDTH'(w);
    assign depth[w*DW +: DW] = sp[w];

    vx_sj_warp_stack #(
      .NUM_THREADS (NUM_THREADS),
      .PC_WIDTH    (PC_WIDTH),
      .STACK_DEPTH (STACK_DEPTH),
      .DW          (DW)
    ) u_stk (
      .clk       (clk),
      .reset     (reset),
      .push      (push_w[w]),
      .mark      (mark_w[w]),
      .pop       (pop_w[w]),
      .flush     (flush_w[w]),
      .push_orig (split_then_tmask | split_else_tmask),
      .push_else (split_else_tmask),
      .push_pc   (split_next_pc),
      .sp        (sp[w]),
      .top_orig  (top_orig[w]),
      .top_else  (top_else[w]),
      .top_pc    (top_pc[w]),
      .top_taken (top_taken[w])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      join_valid   <= 1'b0;
      join_is_dvg  <= 1'b0;
      join_is_else <= 1'b0;
      join_wid     <= '0;
      join_tmask   <= '0;
      join_pc      <= '0;
    end else begin
      join_valid   <= do_join;
      join_is_dvg  <= dvg_join;
      join_is_else <= mark;
      if (do_join) join_wid <= wid;
      join_tmask   <= mark ? sel_else : (pop ? sel_orig : '0);
      join_pc      <= mark ? sel_pc : '0;
    end
  end

  // A clear coinciding with a fresh error leaves exactly that error recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_wid       <= '0;
    end else if (err_clear) begin
      err_overflow  <= overflow;
      err_underflow <= underflow;
      err_wid       <= new_err ? wid : '0;
    end else if (new_err) begin
      err_overflow  <= err_overflow | overflow;
      err_underflow <= err_underflow | underflow;
      if (!err_overflow && !err_underflow) err_wid <= wid;
    end
  end
endmodule

// File: tb/tb_vx_split_join_ext.sv
// Randomized + directed bench for vx_split_join_ext against a queue-based per-warp stack model.

module tb_vx_split_join_ext;
  localparam int NT = 8, NW = 4, NWW = 2, PW = 16, SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic clk = 1'b0, reset;
  logic valid, split_valid, split_is_dvg, sjoin_valid, sjoin_is_dvg, flush_valid, err_clear;
  logic [NWW-1:0] wid, flush_wid;
  logic [NT-1:0]  split_then_tmask, split_else_tmask;
  logic [PW-1:0]  split_next_pc;
  logic join_valid, join_is_dvg, join_is_else, err_overflow, err_underflow;
  logic [NWW-1:0] join_wid, err_wid;
  logic [NT-1:0]  join_tmask;
  logic [PW-1:0]  join_pc;
  logic [NW*DW-1:0] depth;

  vx_split_join_ext #(.NUM_THREADS(NT), .NUM_WARPS(NW), .NW_WIDTH(NWW), .PC_WIDTH(PW),
                      .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .valid(valid), .wid(wid),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
    .split_next_pc(split_next_pc), .sjoin_valid(sjoin_valid), .sjoin_is_dvg(sjoin_is_dvg),
    .flush_valid(flush_valid), .flush_wid(flush_wid), .err_clear(err_clear),
    .join_valid(join_valid), .join_is_dvg(join_is_dvg), .join_is_else(join_is_else),
    .join_wid(join_wid), .join_tmask(join_tmask), .join_pc(join_pc), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_wid(err_wid));

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0] orig;
    logic [NT-1:0] els;
    logic [PW-1:0] pc;
    bit            taken;
  } frm_t;

  frm_t stk[NW][$];
  bit   m_ov, m_un;
  int   m_ewid;
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rs, input bit v, input int w, input bit sv, input bit sd,
                      input logic [NT-1:0] tm, input logic [NT-1:0] em, input logic [PW-1:0] pc,
                      input bit jv, input bit jd, input bit fv, input int fw, input bit ec);
    bit e_jv, e_dvg, e_else, ov, un, drop;
    logic [NT-1:0] e_tm;
    logic [PW-1:0] e_pc;
    frm_t f;
    reset = rs; valid = v; wid = NWW'(w); split_valid = sv; split_is_dvg = sd;
    split_then_tmask = tm; split_else_tmask = em; split_next_pc = pc;
    sjoin_valid = jv; sjoin_is_dvg = jd; flush_valid = fv; flush_wid = NWW'(fw); err_clear = ec;
    e_jv = 0; e_dvg = 0; e_else = 0; e_tm = '0; e_pc = '0; ov = 0; un = 0;
    drop = v && fv && (w == fw);
    if (rs) begin
      for (int i = 0; i < NW; i++) stk[i].delete();
      m_ov = 0; m_un = 0; m_ewid = 0;
    end else begin
      if (v && !drop) begin
        if (sv) begin
          if (sd) begin
            if (stk[w].size() == SD) ov = 1;
            else begin
              f.orig = tm | em; f.els = em; f.pc = pc; f.taken = 0;
              stk[w].push_back(f);
            end
          end
        end else if (jv) begin
          e_jv = 1;
          if (jd) begin
            e_dvg = 1;
            if (stk[w].size() == 0) un = 1;
            else begin
              f = stk[w].pop_back();
              if (!f.taken) begin
                e_else = 1; e_tm = f.els; e_pc = f.pc; f.taken = 1;
                stk[w].push_back(f);
              end else e_tm = f.orig;
            end
          end
        end
      end
      if (fv) stk[fw].delete();
      if (ec) begin
        m_ov = ov; m_un = un; m_ewid = (ov || un) ? w : 0;
      end else if (ov || un) begin
        if (!m_ov && !m_un) m_ewid = w;
        m_ov = m_ov | ov; m_un = m_un | un;
      end
    end
    @(posedge clk); #1;
    chk("join_valid", join_valid, e_jv);
    if (e_jv || rs) begin
      chk("join_is_dvg", join_is_dvg, e_dvg);
      chk("join_is_else", join_is_else, e_else);
      chk("join_tmask", join_tmask, e_tm);
      chk("join_pc", join_pc, e_pc);
      chk("join_wid", join_wid, rs ? 0 : w);
    end
    for (int i = 0; i < NW; i++) chk($sformatf("depth%0d", i), depth[i*DW +: DW], stk[i].size());
    chk("err_overflow", err_overflow, m_ov);
    chk("err_underflow", err_underflow, m_un);
    chk("err_wid", err_wid, m_ewid);
  endtask

  task automatic do_rst();                step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                  step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input int w, input logic [NT-1:0] t, input logic [NT-1:0] e,
                      input logic [PW-1:0] pc);
    step(0, 1, w, 1, 1, t, e, pc, 0, 0, 0, 0, 0);
  endtask
  task automatic sjoin(input int w, input bit d); step(0, 1, w, 0, 0, 0, 0, 0, 1, d, 0, 0, 0); endtask

  initial begin
    do_rst();
    do_rst();
    idle();
    // basic split/join
    push(0, 8'h03, 8'h0C, 16'h0100);
    sjoin(0, 1);
    sjoin(0, 1);
    // nested LIFO
    push(0, 8'h01, 8'h02, 16'h0040);
    push(1, 8'h0F, 8'hF0, 16'h0200);
    push(1, 8'h03, 8'h0C, 16'h0300);
    repeat (4) sjoin(1, 1);
    // overflow, then clear
    repeat (SD + 1) push(2, 8'h11, 8'h22, 16'h0400);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // underflow on empty warp, plus a later error must not move err_wid
    sjoin(3, 1);
    repeat (SD + 1) push(2, 8'h01, 8'h02, 16'h0004);
    // clear coinciding with new error
    step(0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // flush collision drops the op; other warp proceeds
    do_rst();
    push(1, 8'h05, 8'hA0, 16'h0500);
    push(0, 8'h03, 8'h0C, 16'h0100);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    // split wins over join; non-divergent split is a no-op
    step(0, 1, 1, 1, 0, 8'hFF, 8'h00, 16'h0777, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 8'h0F, 8'h30, 16'h0888, 1, 1, 0, 0, 0);
    // non-divergent join, then reset alongside an op
    sjoin(0, 0);
    sjoin(1, 1);
    step(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      int k;
      int w;
      k = $urandom_range(0, 99);
      w = $urandom_range(0, NW - 1);
      step(k == 0, $urandom_range(0, 9) != 0, w, k < 45, $urandom_range(0, 5) != 0,
           NT'($urandom), NT'($urandom), PW'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 5) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, NW - 1),
           $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
